// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port DataMemory between the core load/store
// path (port 0, fixed priority) and a secondary master (port 1). Port 1 is
// protected from starvation by a saturating wait counter that forces a grant.
// Accesses are one word per cycle; responses arrive exactly one cycle after
// acceptance. Misaligned or out-of-range accesses are accepted but never write,
// and they respond with err=1 and rdata=0.
module dmem_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MEM_BYTES = 128,
  parameter int MAX_WAIT  = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          req0_valid,
  input  logic          req0_we,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  output logic          req0_ready,
  output logic          rsp0_valid,
  output logic [DW-1:0] rsp0_rdata,
  output logic          rsp0_err,
  input  logic          req1_valid,
  input  logic          req1_we,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  output logic          req1_ready,
  output logic          rsp1_valid,
  output logic [DW-1:0] rsp1_rdata,
  output logic          rsp1_err,
  output logic [AW-1:0] MEM_A,
  output logic [DW-1:0] MEM_WD,
  output logic          MEM_WE,
  input  logic [DW-1:0] MEM_RD
);

  localparam int            WCW       = $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0] WAIT_MAX = WCW'(MAX_WAIT);
  localparam logic [AW-1:0]  LAST_WORD = AW'(MEM_BYTES - 4);

  // An access is bad when it is not word aligned or runs past the last word.
  function automatic logic addr_bad(input logic [AW-1:0] a);
    return (a[1:0] != 2'b00) || (a > LAST_WORD);
  endfunction

  // Wait counter increment that saturates at MAX_WAIT.
  function automatic logic [WCW-1:0] wait_sat_inc(input logic [WCW-1:0] c);
    return (c == WAIT_MAX) ? c : c + WCW'(1);
  endfunction

  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic           rsp0_valid_q, rsp0_valid_d;
  logic [DW-1:0]  rsp0_rdata_q, rsp0_rdata_d;
  logic           rsp0_err_q, rsp0_err_d;
  logic           rsp1_valid_q, rsp1_valid_d;
  logic [DW-1:0]  rsp1_rdata_q, rsp1_rdata_d;
  logic           rsp1_err_q, rsp1_err_d;

  logic           starve;
  logic           grant0, grant1;
  logic           sel_we;
  logic [AW-1:0]  sel_addr;
  logic [DW-1:0]  sel_wdata;
  logic           sel_bad;
  logic [DW-1:0]  rd_val;

  // Arbitration and memory drive: port 0 wins unless port 1 has starved.
  always_comb begin
    starve    = (wait_cnt_q == WAIT_MAX);
    grant1    = req1_valid & (~req0_valid | starve);
    grant0    = req0_valid & ~grant1;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    if (grant0) begin
      sel_we    = req0_we;
      sel_addr  = req0_addr;
      sel_wdata = req0_wdata;
    end else if (grant1) begin
      sel_we    = req1_we;
      sel_addr  = req1_addr;
      sel_wdata = req1_wdata;
    end
    sel_bad    = addr_bad(sel_addr);
    req0_ready = grant0 & ~RST;
    req1_ready = grant1 & ~RST;
    MEM_A      = sel_addr;
    MEM_WD     = sel_wdata;
    MEM_WE     = sel_we & ~sel_bad & ~RST;
  end

  // Next-state: starvation counter and per-port response capture.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!req1_valid || grant1) begin
      wait_cnt_d = '0;
    end else begin
      wait_cnt_d = wait_sat_inc(wait_cnt_q);
    end

    rd_val = (~sel_we & ~sel_bad) ? MEM_RD : '0;

    rsp0_valid_d = req0_ready;
    rsp0_rdata_d = rsp0_rdata_q;
    rsp0_err_d   = rsp0_err_q;
    if (req0_ready) begin
      rsp0_rdata_d = rd_val;
      rsp0_err_d   = sel_bad;
    end

    rsp1_valid_d = req1_ready;
    rsp1_rdata_d = rsp1_rdata_q;
    rsp1_err_d   = rsp1_err_q;
    if (req1_ready) begin
      rsp1_rdata_d = rd_val;
      rsp1_err_d   = sel_bad;
    end
  end

  // State registers; reset drops any pending response immediately.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wait_cnt_q   <= '0;
      rsp0_valid_q <= 1'b0;
      rsp0_rdata_q <= '0;
      rsp0_err_q   <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp1_rdata_q <= '0;
      rsp1_err_q   <= 1'b0;
    end else begin
      wait_cnt_q   <= wait_cnt_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp0_rdata_q <= rsp0_rdata_d;
      rsp0_err_q   <= rsp0_err_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp1_rdata_q <= rsp1_rdata_d;
      rsp1_err_q   <= rsp1_err_d;
    end
  end

  assign rsp0_valid = rsp0_valid_q;
  assign rsp0_rdata = rsp0_rdata_q;
  assign rsp0_err   = rsp0_err_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp1_rdata = rsp1_rdata_q;
  assign rsp1_err   = rsp1_err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: drives dmem_arbiter against a behavioural DataMemory,
// predicts grants with an independent arbitration model and checks every
// response against a scoreboard of expected results.
module tb_dmem_arbiter;

  localparam int AW        = 32;
  localparam int DW        = 32;
  localparam int MEM_BYTES = 128;
  localparam int MAX_WAIT  = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic          req0_valid, req0_we, req0_ready, rsp0_valid, rsp0_err;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata, rsp0_rdata;
  logic          req1_valid, req1_we, req1_ready, rsp1_valid, rsp1_err;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata, rsp1_rdata;
  logic [AW-1:0] MEM_A;
  logic [DW-1:0] MEM_WD, MEM_RD;
  logic          MEM_WE;

  dmem_arbiter #(
    .AW(AW), .DW(DW), .MEM_BYTES(MEM_BYTES), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .CLK(CLK), .RST(RST),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .MEM_A(MEM_A), .MEM_WD(MEM_WD), .MEM_WE(MEM_WE), .MEM_RD(MEM_RD)
  );

  always #5 CLK = ~CLK;

  // Behavioural single-port DataMemory: combinational read, write at the edge.
  logic [DW-1:0] mem [0:31] = '{default: '0};
  assign MEM_RD = mem[MEM_A[6:2]];
  always @(posedge CLK) if (MEM_WE) mem[MEM_A[6:2]] <= MEM_WD;

  // Reference state owned by the bench.
  logic [DW-1:0] ref_mem [0:31] = '{default: '0};
  int            tb_wait = 0;
  int            cyc = 0;
  int            n_tests = 0;
  int            n_fail = 0;
  int            both_cnt = 0;
  logic          last_r1;
  logic          acc0, acc1;

  typedef struct {
    int            due;
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic is_bad(input logic [AW-1:0] a);
    return (a[1:0] != 2'b00) || (a > AW'(MEM_BYTES - 4));
  endfunction

  // One clock cycle: predict grants at the falling edge, check, log expectations.
  task automatic tick();
    logic          st, g0, g1, e0, e1, we, bad;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd, rd;
    exp_t          e;
    @(negedge CLK);
    st = (tb_wait == MAX_WAIT);
    g1 = req1_valid & (~req0_valid | st);
    g0 = req0_valid & ~g1;
    e0 = g0 & ~RST;
    e1 = g1 & ~RST;
    chk("ready0", {31'b0, req0_ready}, {31'b0, e0});
    chk("ready1", {31'b0, req1_ready}, {31'b0, e1});
    if (req0_ready && req1_ready) both_cnt++;
    last_r1 = req1_ready;
    acc0 = e0;
    acc1 = e1;
    if (e0 || e1) begin
      we   = e0 ? req0_we    : req1_we;
      addr = e0 ? req0_addr  : req1_addr;
      wd   = e0 ? req0_wdata : req1_wdata;
      bad  = is_bad(addr);
      chk("mem_a", MEM_A, addr);
      chk("mem_we", {31'b0, MEM_WE}, {31'b0, we & ~bad});
      if (we && !bad) chk("mem_wd", MEM_WD, wd);
      rd = (!we && !bad) ? ref_mem[addr[6:2]] : '0;
      if (we && !bad) ref_mem[addr[6:2]] = wd;
      e.due = cyc + 1;
      e.rdata = rd;
      e.err = bad;
      if (e0) q0.push_back(e);
      else    q1.push_back(e);
    end else begin
      chk("mem_we_idle", {31'b0, MEM_WE}, 32'd0);
    end
    if (RST || !req1_valid || g1) tb_wait = 0;
    else if (tb_wait < MAX_WAIT) tb_wait++;
    @(posedge CLK);
    #1;
  endtask

  // Response monitor: rsp_valid must match the scoreboard exactly.
  always @(negedge CLK) begin
    logic ev0, ev1;
    exp_t e;
    ev0 = (q0.size() > 0) && (q0[0].due <= cyc);
    ev1 = (q1.size() > 0) && (q1[0].due <= cyc);
    chk("rsp0_valid", {31'b0, rsp0_valid}, {31'b0, ev0});
    chk("rsp1_valid", {31'b0, rsp1_valid}, {31'b0, ev1});
    if (ev0) begin
      e = q0.pop_front();
      chk("rsp0_rdata", rsp0_rdata, e.rdata);
      chk("rsp0_err", {31'b0, rsp0_err}, {31'b0, e.err});
    end
    if (ev1) begin
      e = q1.pop_front();
      chk("rsp1_rdata", rsp1_rdata, e.rdata);
      chk("rsp1_err", {31'b0, rsp1_err}, {31'b0, e.err});
    end
  end

  // Issue one access on a port and hold it until accepted (bounded).
  task automatic access(input int port, input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd, output int waited);
    waited = 0;
    if (port == 0) begin
      req0_valid = 1'b1; req0_we = we; req0_addr = addr; req0_wdata = wd;
    end else begin
      req1_valid = 1'b1; req1_we = we; req1_addr = addr; req1_wdata = wd;
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      waited++;
      if ((port == 0) ? acc0 : acc1) break;
    end
    if (!((port == 0) ? acc0 : acc1)) chk("accept_timeout", 32'd0, 32'd1);
    if (port == 0) req0_valid = 1'b0;
    else           req1_valid = 1'b0;
  endtask

  initial begin
    int            w;
    logic [9:0]    p1_mask;
    logic [5:0]    p1_mask_rst;

    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         w;
    logic [9:0] p1_mask;
    logic [5:0] p1_mask_rst;

    RST = 1'b1;
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0;
    #2;
    chk("rst_rsp0_valid", {31'b0, rsp0_valid}, 32'd0);
    chk("rst_rsp0_rdata", rsp0_rdata, 32'd0);
    chk("rst_rsp1_err", {31'b0, rsp1_err}, 32'd0);
    chk("rst_ready0", {31'b0, req0_ready}, 32'd0);
    tick();
    tick();
    RST = 1'b0;
    req0_valid = 1'b0;

    // Port 0 writes and reads back; first access in the first cycle out of reset.
    access(0, 1'b1, 32'h00, 32'hDEADBEEF, w);
    chk("first_accept_latency", w, 1);
    access(0, 1'b1, 32'h7C, 32'h12345678, w);
    access(0, 1'b0, 32'h00, 32'h0, w);
    access(0, 1'b0, 32'h7C, 32'h0, w);

    // Both ports valid for 10 cycles: port 1 forced through on 5 and 10.
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 32'h00;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 32'h7C;
    both_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      p1_mask[i] = last_r1;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("p1_grant_pattern", {22'b0, p1_mask}, 32'h210);
    chk("both_ready", both_cnt, 0);

    // Bad accesses: accepted with err, never written.
    access(0, 1'b1, 32'h04, 32'h11112222, w);
    access(0, 1'b1, 32'h06, 32'hFFFFFFFF, w);
    access(0, 1'b0, 32'h80, 32'h0, w);
    access(0, 1'b0, 32'h04, 32'h0, w);

    // Read-after-write on consecutive cycles.
    access(0, 1'b1, 32'h10, 32'hA5A5A5A5, w);
    access(0, 1'b0, 32'h10, 32'h0, w);

    // Port 1 alone is granted immediately; port 0 reads its data.
    access(1, 1'b1, 32'h20, 32'h0000FFFF, w);
    chk("p1_immediate", w, 1);
    access(0, 1'b0, 32'h20, 32'h0, w);

    // Reset between acceptance and response.
    req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 32'h30; req0_wdata = 32'h55AA55AA;
    tick();
    chk("rsp_before_rst", {31'b0, rsp0_valid}, 32'd1);
    RST = 1'b1;
    #1;
    chk("rst_async_valid", {31'b0, rsp0_valid}, 32'd0);
    chk("rst_async_rdata", rsp0_rdata, 32'd0);
    q0.delete();
    q1.delete();
    req0_addr = 32'h34; req0_wdata = 32'hBADBAD00;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 32'h7C;
    tick();
    tick();
    req0_we = 1'b0; req0_addr = 32'h30;
    RST = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      p1_mask_rst[i] = last_r1;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("wait_restart", {26'b0, p1_mask_rst}, 32'h10);
    access(0, 1'b0, 32'h34, 32'h0, w);

    tick();
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-port DataMemory between the core load/store path (port 0) and a secondary master such as a program/data loader or debug port (port 1). It accepts one word access per cycle over valid/ready handshakes and drives the memory's address, write-data and write-enable. It registers the memory's combinational read data into a one-cycle-latency response, and flags misaligned or out-of-range accesses. Port 0 has fixed priority; a wait counter guarantees port 1 a grant within a bounded number of cycles.

## Interface
- AW, 32, address width (bits)
- DW, 32, data width (bits); equals DataMemory word width
- MEM_BYTES, 128, implemented memory size in bytes; multiple of 4
- MAX_WAIT, 4, cycles port 1 may be refused before forced grant; >=1
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  reset, asynchronous, active-high
- req0_valid / req1_valid  in  1  request present
- req0_we / req1_we  in  1  1 = write, 0 = read
- req0_addr / req1_addr  in  AW  byte address
- req0_wdata / req1_wdata  in  DW  write data
- req0_ready / req1_ready  out  1  request accepted this cycle (combinational)
- rsp0_valid / rsp1_valid  out  1  response pulse, one cycle after acceptance
- rsp0_rdata / rsp1_rdata  out  DW  read data (0 for writes and errors)
- rsp0_err / rsp1_err  out  1  access was misaligned or out of range
- MEM_A  out  AW  DataMemory address
- MEM_WD  out  DW  DataMemory write data
- MEM_WE  out  1  DataMemory write enable
- MEM_RD  in  DW  DataMemory read data (combinational from MEM_A)

## Operation
- Arbitration, combinational each cycle:
  - grant1 = req1_valid & (~req0_valid | starve).
  - grant0 = req0_valid & ~grant1.
  - reqN_ready = grantN & ~RST.
  - At most one ready is high per cycle.
- starve = (wait_cnt == MAX_WAIT).
- wait_cnt register, width clog2(MAX_WAIT+1):
  - Cleared on grant1 or when req1_valid is low.
  - Otherwise increments while req1_valid & ~grant1, saturating at MAX_WAIT.
- Memory drive:
  - MEM_A and MEM_WD come from the granted port. With no grant, MEM_A = 0 and MEM_WD = 0.
  - MEM_WE = granted we & ~bad & ~RST.
- bad = (addr[1:0] != 0) | (addr > MEM_BYTES-4).
  - A bad access is still accepted (ready high), never writes, and returns err=1 with rdata=0.
- Response registers, per port:
  - On acceptance: rspN_valid <= 1, rspN_err <= bad, rspN_rdata <= (~we & ~bad) ? MEM_RD : 0.
  - Without acceptance: rspN_valid <= 0; rdata and err hold their value.
- Requesters must hold valid, we, addr and wdata stable until ready. The arbiter does not buffer refused requests.
- Reset (asserted at any time, including mid-transaction):
  - rsp*_valid = 0, rsp*_rdata = 0, rsp*_err = 0, wait_cnt = 0 immediately.
  - ready and MEM_WE are forced low while RST is high.
  - A response pending at reset assertion is dropped, not replayed.

## Timing
- Acceptance cycle T: MEM_* are driven combinationally in T. The write commits at the rising edge ending T. The read samples MEM_RD at the same edge.
- Response: rspN_valid is high for exactly cycle T+1.
- Throughput: one access per cycle total. Back-to-back accepts on the same port give a continuous rsp_valid.
- Read-after-write to the same address on consecutive cycles returns the newly written data.
- Simultaneous valid on both ports with wait_cnt < MAX_WAIT: port 0 is granted and wait_cnt increments.
- Port 1 worst-case wait from its valid rising: MAX_WAIT refused cycles, then granted on cycle MAX_WAIT+1. This holds even with port 0 continuously valid.
- Reset deassertion: first acceptance can occur in the first cycle RST is low.

## Test plan
- Port 0 only: writes of 0xDEADBEEF to 0x00 and 0x12345678 to 0x7C, then reads of both. Expected: each write gives rsp0_valid in T+1 with rdata 0; the reads return the written values in T+1 with err=0.
- Both ports valid every cycle for 10 cycles, MAX_WAIT=4. Expected: port 1 ready on cycles 5 and 10 only, port 0 ready otherwise, and no cycle with both ready high.
- Misaligned write to 0x06 and out-of-range read at 0x80. Expected: both accepted, err=1, rdata=0; word 0x04 is unchanged on readback; MEM_WE is never high.
- Write 0xA5A5A5A5 to 0x10 in cycle T, read 0x10 in T+1. Expected: read returns 0xA5A5A5A5 in T+2.
- Port 1 write to 0x20 with 0x0000FFFF while port 0 is idle. Expected: immediate grant; port 0 then reads 0x0000FFFF from 0x20.
- RST asserted mid-stream between acceptance and response. Expected: rsp_valid goes 0 without waiting for CLK, no write occurs while RST is high, and wait_cnt restarts from 0 after release.
